// File: rtl/fft_sample_buffer_if.sv
// Signal bundle between the sample buffer, the Avalon write slave and the FFT core.
// out_* is a valid/ready stream: a beat transfers on a rising clk edge where out_valid && out_ready; once raised, out_valid and its payload hold until accepted.
interface fft_sample_buffer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fft_start;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              overrun_err;

  modport master (
    output wr_en, wr_addr, wr_data, fft_start, out_ready,
    input  out_data, out_index, out_valid, busy, done, overrun_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, fft_start, out_ready,
    output out_data, out_index, out_valid, busy, done, overrun_err
  );
endinterface

// File: rtl/fft_sample_buffer.sv
// Frame store for the FFT: captures DEPTH samples, then streams them out in
// bit-reversed (or natural) address order over a valid/ready interface.
module fft_sample_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int BITREV = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  fft_sample_buffer_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              busy_int;
  logic              accepting;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [ADDR_W-1:0] raddr(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] rev;
    for (int b = 0; b < ADDR_W; b++) rev[b] = idx[ADDR_W-1-b];
    return (BITREV != 0) ? rev : idx;
  endfunction

  assign busy_int    = (state == PRIME) || (state == STREAM);
  assign accepting   = (state == IDLE) || (state == DONE);
  assign bus.busy    = busy_int;
  assign bus.done    = (state == DONE);
  assign state_dbg   = state;

  // PRIME fetches position 0; during STREAM the next position is prefetched
  // so an accepted beat is replaced on the same edge.
  assign cnt_inc = cnt + ADDR_W'(1);
  assign rd_idx  = (state == PRIME) ? '0 : cnt_inc;
  assign rd_word = mem[raddr(rd_idx)];

  always_ff @(posedge clk) begin
    if (n_rst && accepting && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.fft_start) next_state = PRIME;
      PRIME:   next_state = STREAM;
      STREAM:  if (bus.out_ready && cnt == LAST) next_state = DONE;
      DONE:    next_state = bus.fft_start ? PRIME : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt             <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_index   <= '0;
      bus.overrun_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.fft_start) begin
            cnt             <= '0;
            bus.overrun_err <= 1'b0;
          end
        end
        PRIME: begin
          bus.out_data  <= rd_word;
          bus.out_index <= '0;
          bus.out_valid <= 1'b1;
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (cnt == LAST) begin
              bus.out_valid <= 1'b0;
            end else begin
              cnt           <= cnt_inc;
              bus.out_data  <= rd_word;
              bus.out_index <= cnt_inc;
            end
          end
        end
        default: ;
      endcase
      // Writes and restarts are dropped while streaming; flag them.
      if (busy_int && (bus.wr_en || bus.fft_start)) bus.overrun_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_sample_buffer.sv
// Directed bench for fft_sample_buffer: one bit-reversed instance and one
// natural-order instance share clock and reset.
module tb_fft_sample_buffer;
  logic clk = 1'b0;
  logic n_rst;
  logic [1:0] br_state, nat_state;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [512];
  logic [31:0] exp_q [$];
  logic [31:0] first_data [5];
  logic [31:0] first_exp [5] = '{32'd0, 32'd256, 32'd128, 32'd384, 32'd64};

  always #5 clk = ~clk;

  fft_sample_buffer_if #(.ADDR_W(9), .DATA_W(32)) br_if ();
  fft_sample_buffer_if #(.ADDR_W(9), .DATA_W(32)) nat_if ();

  fft_sample_buffer #(.ADDR_W(9), .DATA_W(32), .BITREV(1)) dut_br (
    .clk(clk), .n_rst(n_rst), .bus(br_if.slave), .state_dbg(br_state)
  );

  fft_sample_buffer #(.ADDR_W(9), .DATA_W(32), .BITREV(0)) dut_nat (
    .clk(clk), .n_rst(n_rst), .bus(nat_if.slave), .state_dbg(nat_state)
  );

  function automatic logic [8:0] bitrev9(input int i);
    logic [8:0] v;
    logic [8:0] r;
    v = i[8:0];
    for (int b = 0; b < 9; b++) r[b] = v[8-b];
    return r;
  endfunction

  task automatic load_br_frame();
    for (int a = 0; a < 512; a++) begin
      br_if.wr_en   = 1'b1;
      br_if.wr_addr = a[8:0];
      br_if.wr_data = a;
      model[a]      = a;
      @(negedge clk);
    end
    br_if.wr_en = 1'b0;
  endtask

  // Starts a frame on the bit-reversed instance and checks every beat.
  task automatic collect_frame(input string name, input bit bp, input int inject_at,
                               input int abort_at);
    int exp_i;
    int done_cnt;
    bit ready_now;
    bit stalled;
    logic [31:0] hold_d;
    logic [8:0] hold_i;
    logic [31:0] exp_d;
    exp_i = 0; done_cnt = 0; stalled = 0; hold_d = '0; hold_i = '0;
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(model[bitrev9(i)]);
    br_if.out_ready = 1'b0;
    br_if.fft_start = 1'b1;
    @(negedge clk);
    br_if.fft_start = 1'b0;
    br_if.wr_en     = 1'b0;
    vectors++;
    if ({br_if.busy, br_if.out_valid, br_if.overrun_err} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s prime {busy,valid,err}: got %b expected 100", name,
               {br_if.busy, br_if.out_valid, br_if.overrun_err});
    end
    @(negedge clk);
    vectors++;
    if (br_if.out_valid !== 1'b1 || br_if.out_index !== 9'd0) begin
      miscompares++;
      $display("FAIL %s first_valid: got valid=%b index=%0d expected valid=1 index=0", name,
               br_if.out_valid, br_if.out_index);
    end
    for (int c = 0; c < 4000; c++) begin
      if (br_if.done === 1'b1) done_cnt++;
      if (stalled) begin
        vectors++;
        if (br_if.out_valid !== 1'b1 || br_if.out_data !== hold_d || br_if.out_index !== hold_i) begin
          miscompares++;
          $display("FAIL %s stall_hold: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d", name,
                   br_if.out_valid, br_if.out_data, br_if.out_index, hold_d, hold_i);
        end
      end
      br_if.wr_en     = 1'b0;
      br_if.fft_start = 1'b0;
      if (abort_at >= 0 && exp_i == abort_at) begin
        n_rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({br_if.out_valid, br_if.busy, br_if.done} !== 3'b000 || br_if.out_index !== 9'd0 ||
            br_if.out_data !== 32'd0) begin
          miscompares++;
          $display("FAIL %s abort_reset: got v/b/d=%b i=%0d d=%h expected 000 0 0", name,
                   {br_if.out_valid, br_if.busy, br_if.done}, br_if.out_index, br_if.out_data);
        end
        n_rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if ({br_if.out_valid, br_if.busy, br_if.done} !== 3'b000) begin
          miscompares++;
          $display("FAIL %s abort_no_done: got v/b/d=%b expected 000", name,
                   {br_if.out_valid, br_if.busy, br_if.done});
        end
        return;
      end
      if (inject_at >= 0 && exp_i == inject_at) begin
        br_if.wr_en     = 1'b1;
        br_if.wr_addr   = 9'd5;
        br_if.wr_data   = 32'hDEAD_BEEF;
        br_if.fft_start = 1'b1;
      end
      ready_now = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      br_if.out_ready = ready_now;
      if (!bp) begin
        vectors++;
        if (br_if.out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL %s bubble at beat %0d: got valid=%b expected 1", name, exp_i,
                   br_if.out_valid);
        end
      end
      if (br_if.out_valid === 1'b1 && ready_now) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        if (exp_i < 5) first_data[exp_i] = br_if.out_data;
        vectors++;
        if (br_if.out_index !== exp_i[8:0] || br_if.out_data !== exp_d) begin
          miscompares++;
          $display("FAIL %s beat %0d: got i=%0d d=%h expected i=%0d d=%h", name, exp_i,
                   br_if.out_index, br_if.out_data, exp_i, exp_d);
        end
        exp_i++;
      end
      stalled = (br_if.out_valid === 1'b1) && !ready_now;
      hold_d  = br_if.out_data;
      hold_i  = br_if.out_index;
      @(negedge clk);
      if (exp_i == 512) break;
    end
    vectors++;
    if (exp_i != 512 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d beats, %0d early done expected 512, 0", name,
               exp_i, done_cnt);
    end
    vectors++;
    if ({br_if.done, br_if.out_valid, br_if.busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL %s done_pulse {done,valid,busy}: got %b expected 100", name,
               {br_if.done, br_if.out_valid, br_if.busy});
    end
    br_if.out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({br_if.done, br_if.out_valid, br_if.busy, br_if.overrun_err} !== {3'b000, inject_at >= 0}) begin
      miscompares++;
      $display("FAIL %s after_done {done,valid,busy,err}: got %b expected %b", name,
               {br_if.done, br_if.out_valid, br_if.busy, br_if.overrun_err},
               {3'b000, inject_at >= 0});
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    br_if.wr_en = 1'b1;  br_if.fft_start = 1'b1;
    nat_if.wr_en = 1'b1; nat_if.fft_start = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({br_if.out_valid, br_if.busy, br_if.done, br_if.overrun_err, br_state} !== 6'd0 ||
        br_if.out_data !== 32'd0 || br_if.out_index !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_br: got flags=%b d=%h i=%0d expected all zero",
               {br_if.out_valid, br_if.busy, br_if.done, br_if.overrun_err, br_state},
               br_if.out_data, br_if.out_index);
    end
    vectors++;
    if ({nat_if.out_valid, nat_if.busy, nat_if.done, nat_if.overrun_err, nat_state} !== 6'd0 ||
        nat_if.out_data !== 32'd0 || nat_if.out_index !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_nat: got flags=%b d=%h i=%0d expected all zero",
               {nat_if.out_valid, nat_if.busy, nat_if.done, nat_if.overrun_err, nat_state},
               nat_if.out_data, nat_if.out_index);
    end
    br_if.wr_en = 1'b0;  br_if.fft_start = 1'b0;
    nat_if.wr_en = 1'b0; nat_if.fft_start = 1'b0;
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({br_if.out_valid, br_if.busy, nat_if.out_valid, nat_if.busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected 0000",
               {br_if.out_valid, br_if.busy, nat_if.out_valid, nat_if.busy});
    end
  endtask

  task automatic test_full_frame();
    load_br_frame();
    collect_frame("full_frame", 1'b0, -1, -1);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (first_data[k] !== first_exp[k]) begin
        miscompares++;
        $display("FAIL first_order[%0d]: got %0d expected %0d", k, first_data[k], first_exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    collect_frame("backpressure", 1'b1, -1, -1);
  endtask

  task automatic test_natural();
    for (int a = 0; a < 512; a++) begin
      nat_if.wr_en   = 1'b1;
      nat_if.wr_addr = a[8:0];
      nat_if.wr_data = 32'hA500_0000 | a;
      @(negedge clk);
    end
    nat_if.wr_en     = 1'b0;
    nat_if.out_ready = 1'b1;
    nat_if.fft_start = 1'b1;
    @(negedge clk);
    nat_if.fft_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      vectors++;
      if (nat_if.out_valid !== 1'b1 || nat_if.out_index !== i[8:0] ||
          nat_if.out_data !== (32'hA500_0000 | i)) begin
        miscompares++;
        $display("FAIL natural beat %0d: got v=%b i=%0d d=%h expected v=1 i=%0d d=%h", i,
                 nat_if.out_valid, nat_if.out_index, nat_if.out_data, i, 32'hA500_0000 | i);
      end
      @(negedge clk);
    end
    vectors++;
    if ({nat_if.done, nat_if.out_valid, nat_if.busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL natural_done {done,valid,busy}: got %b expected 100",
               {nat_if.done, nat_if.out_valid, nat_if.busy});
    end
    nat_if.out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    collect_frame("overrun", 1'b0, 100, -1);
    repeat (3) @(negedge clk);
    vectors++;
    if (br_if.overrun_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %b expected 1", br_if.overrun_err);
    end
    // model[5] is untouched, so this frame also proves the dropped write.
    collect_frame("after_overrun", 1'b0, -1, -1);
  endtask

  task automatic test_reset_midstream();
    collect_frame("abort", 1'b0, -1, 300);
  endtask

  task automatic test_same_cycle();
    br_if.wr_en   = 1'b1;
    br_if.wr_addr = 9'd0;
    br_if.wr_data = 32'h1234;
    model[0]      = 32'h1234;
    collect_frame("same_cycle", 1'b0, -1, -1);
    vectors++;
    if (first_data[0] !== 32'h1234) begin
      miscompares++;
      $display("FAIL same_cycle_first: got %h expected 00001234", first_data[0]);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    br_if.wr_en = 1'b0;  br_if.wr_addr = '0;  br_if.wr_data = '0;
    br_if.fft_start = 1'b0;  br_if.out_ready = 1'b0;
    nat_if.wr_en = 1'b0; nat_if.wr_addr = '0; nat_if.wr_data = '0;
    nat_if.fft_start = 1'b0; nat_if.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_backpressure();
    test_natural();
    test_overrun();
    test_reset_midstream();
    test_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
